io_bridge: RTL

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge_pkg.sv | 20 ++
 rtl/io_fifo.sv | 49 ++++
 rtl/io_bridge.sv | 82 ++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
// Shared defaults and bit positions for the CPU <-> external byte bridge.
package io_bridge_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  localparam int TX_FULL  = 3;
  localparam int TX_EMPTY = 2;
  localparam int RX_FULL  = 1;
  localparam int RX_EMPTY = 0;

  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_UNF = 1;

  typedef struct packed {
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
  } status_t;
endpackage

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Push is judged on the registered full flag, so a same-cycle pop never frees a slot.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= data;
  end

  assign head = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/io_bridge.sv
// Byte bridge between a CPU OUT/INP register pair and an external valid/ready stream.
// Handshake: a byte moves when valid and ready are both high at a rising edge; valid never
// drops and data never changes until that happens.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_out_wr,
  input  logic [WIDTH-1:0] cpu_out_data,
  input  logic             cpu_in_rd,
  output logic [WIDTH-1:0] cpu_in_data,
  output logic             cpu_in_valid,
  input  logic             err_clr,
  output logic             ext_tx_valid,
  output logic [WIDTH-1:0] ext_tx_data,
  input  logic             ext_tx_ready,
  input  logic             ext_rx_valid,
  input  logic [WIDTH-1:0] ext_rx_data,
  output logic             ext_rx_ready,
  output logic [3:0]       status,
  output logic [1:0]       err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [AW:0]   tx_count, rx_count;
  logic [1:0]    err_set;
  status_t       st;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_out_wr),
    .pop   (ext_tx_ready),
    .data  (cpu_out_data),
    .head  (ext_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (ext_rx_valid),
    .pop   (cpu_in_rd),
    .data  (ext_rx_data),
    .head  (cpu_in_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign ext_tx_valid = !tx_empty;
  assign cpu_in_valid = !rx_empty;
  assign ext_rx_ready = !rx_full;

  always_comb begin
    st.tx_full  = (tx_count == FULL_CNT);
    st.tx_empty = (tx_count == '0);
    st.rx_full  = (rx_count == FULL_CNT);
    st.rx_empty = (rx_count == '0);
  end
  assign status = st;

  always_comb begin
    err_set             = '0;
    err_set[ERR_TX_OVF] = cpu_out_wr && tx_full;
    err_set[ERR_RX_UNF] = cpu_in_rd && rx_empty;
  end

  // A new error in the same cycle as err_clr wins, so the flag stays set.
  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= (err & {2{~err_clr}}) | err_set;
  end
endmodule
